mc_alu_ctrl: RTL
================

# mc_alu_ctrl

Multi-cycle MIPS control unit: the initiator side of the ALU interface. It sequences each instruction through a Moore FSM and drives the ALU's `aluop`, `slt_sel` and `flagsel` controls. It consumes the ALU's `zero` and `flag` outputs and drives datapath mux, enable and write strobes for a shared-memory multi-cycle datapath. Overflow and illegal-instruction events are reported as one-cycle pulses.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `op`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero.
- `flag`  in  1  ALU signed-overflow flag.
- `aluop`  out  2  00 add, 01 sub, 10 or, 11 zero.
- `slt_sel`  out  1  ALU returns sign bit of result.
- `flagsel`  out  1  enables ALU overflow detection.
- `alusrca`  out  1  0 = PC, 1 = A register.
- `alusrcb`  out  2  00 B, 01 const 4, 10 extended imm, 11 sext imm<<2.
- `immzext`  out  1  1 = zero-extend imm (ori), else sign-extend.
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `irwrite`, `memwrite`, `regwrite`  out  1 each  write strobes.
- `regdst`  out  1  1 = rd, 0 = rt.
- `memtoreg`  out  1  1 = data register, 0 = ALUOut.
- `pcsrc`  out  2  00 ALU, 01 ALUOut, 10 jump target.
- `pc_en`  out  1  PC load enable.
- `ovf_exc`  out  1  overflow pulse.
- `ill_exc`  out  1  illegal-instruction pulse.
- `state`  out  4  current state, debug only.

## Operation
- States and encodings: RST 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, RTEXEC 7, ALUWB 8, BRANCH 9, IEXEC 10, IWB 11, JUMP 12. Codes 13–15 go to FETCH.
- Default for every output is 0. Each state asserts only what is listed below.
- RST: all outputs 0. Next state is FETCH.
- FETCH: `irwrite`, `alusrcb`=01, aluop 00, `pc_en`. Next state is DECODE.
- DECODE: `alusrcb`=11, aluop 00 (computes branch target into ALUOut). Next state depends on `op`:
  - 23h or 2Bh go to MEMADR.
  - 00h with funct 20h/22h/25h/2Ah goes to RTEXEC.
  - 04h goes to BRANCH.
  - 08h or 0Dh go to IEXEC.
  - 02h goes to JUMP.
  - Any other op/funct pulses `ill_exc` in DECODE and goes to FETCH.
- MEMADR: `alusrca`, `alusrcb`=10, aluop 00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`. Next state is MEMWB.
- MEMWB: `regwrite`, `memtoreg`. Next state is FETCH.
- MEMWR: `iord`, `memwrite`. Next state is FETCH.
- RTEXEC: `alusrca`, `alusrcb`=00. Per funct:
  - add: aluop 00 with `flagsel`.
  - sub: aluop 01 with `flagsel`.
  - or: aluop 10.
  - slt: aluop 01 with `slt_sel`.
  - Next state is ALUWB.
- ALUWB: `regdst`; `regwrite` = !ovf_q; `ovf_exc` = ovf_q. Next state is FETCH.
- BRANCH: `alusrca`, `alusrcb`=00, aluop 01, `pcsrc`=01, `pc_en` = `zero`. `slt_sel` and `flagsel` stay 0. Next state is FETCH.
- IEXEC: `alusrca`, `alusrcb`=10.
  - addi: aluop 00 with `flagsel`.
  - ori: aluop 10 with `immzext`.
  - Next state is IWB.
- IWB: `regwrite` = !ovf_q; `ovf_exc` = ovf_q. Next state is FETCH.
- JUMP: `pcsrc`=10, `pc_en`. Next state is FETCH.
- ovf_q register:
  - Loads `flag & flagsel` at the end of every RTEXEC and IEXEC cycle.
  - Holds its value in all other states.
  - Cleared by reset.
  - The ALU's inputs change after EXEC, so the flag must be captured there and never sampled in writeback.
- `ovf_exc` never blocks PC advance. The faulting instruction only loses its register write.

## Timing
- Registered: `state` and ovf_q only. All outputs are combinational from state, plus `zero` (BRANCH) and ovf_q (writeback states).
- Reset:
  - `reset` high at a rising edge sets state to RST and clears ovf_q.
  - While state is RST, every output is 0 and `state`=0.
  - The first FETCH is the cycle after `reset` deasserts.
- Reset mid-instruction abandons it. Nothing asserted in the abandoned cycle after the reset edge may remain asserted.
- Instruction latency in cycles: lw 5; sw 4; R-type 4; addi/ori 4; beq 3; j 3; illegal 2.
- `ovf_exc` and `ill_exc` are exactly one cycle wide.
- Back-to-back instructions have no idle cycle between them: FETCH follows directly.

## Test plan
- Reset held for 3 cycles, then released → `state`=0 and all outputs 0 during reset and the cycle after; next cycle `state`=1 with `irwrite`=`pc_en`=1, `alusrcb`=01.
- op=00h, funct=22h (sub), `flag`=0 → state sequence 1,2,7,8,1; in state 7, aluop=01 and `flagsel`=1; in state 8, `regwrite`=1 and `regdst`=1.
- op=00h, funct=20h, `flag`=1 in RTEXEC, `flag`=0 in ALUWB → in ALUWB, `regwrite`=0 and `ovf_exc`=1 for one cycle; the next instruction fetches normally.
- op=04h with `zero`=1, then `zero`=0 → `pc_en`=1 and `pcsrc`=01 in BRANCH, then `pc_en`=0; `slt_sel`=`flagsel`=0 in both cases.
- op=00h, funct=2Ah → aluop=01, `slt_sel`=1, `flagsel`=0; ovf_q stays 0 even with `flag`=1.
- op=3Fh → `ill_exc`=1 in DECODE only, then FETCH; with op=23h, `reset` asserted during MEMRD → RST on the next edge with `iord`=0.

Source files
------------

// File: rtl/mc_alu_ctrl.sv
// Multi-cycle MIPS control FSM driving the ALU and datapath strobes.
// Outputs are Moore-decoded from state, plus zero in BRANCH and ovf_q in writeback.
module mc_alu_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       flag,
  output logic [1:0] aluop,
  output logic       slt_sel,
  output logic       flagsel,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       immzext,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] pcsrc,
  output logic       pc_en,
  output logic       ovf_exc,
  output logic       ill_exc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXEC = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RT   = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  state_t state_q, state_d;
  logic   ovf_q, ovf_d;

  logic is_mem, is_rt, is_beq, is_imm, is_j;
  logic fn_ok;

  always_comb begin
    fn_ok = (funct == FN_ADD) || (funct == FN_SUB) ||
            (funct == FN_OR)  || (funct == FN_SLT);
    is_mem = (op == OP_LW) || (op == OP_SW);
    is_rt  = (op == OP_RT) && fn_ok;
    is_beq = (op == OP_BEQ);
    is_imm = (op == OP_ADDI) || (op == OP_ORI);
    is_j   = (op == OP_J);
  end

  always_comb begin
    state_d  = S_FETCH;
    ovf_d    = ovf_q;
    aluop    = 2'b00;
    slt_sel  = 1'b0;
    flagsel  = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    immzext  = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    pcsrc    = 2'b00;
    pc_en    = 1'b0;
    ovf_exc  = 1'b0;
    ill_exc  = 1'b0;
    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        aluop   = ALU_ADD;
        pc_en   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // branch target is precomputed into ALUOut here
        alusrcb = 2'b11;
        aluop   = ALU_ADD;
        unique case (1'b1)
          is_mem:  state_d = S_MEMADR;
          is_rt:   state_d = S_RTEXEC;
          is_beq:  state_d = S_BRANCH;
          is_imm:  state_d = S_IEXEC;
          is_j:    state_d = S_JUMP;
          default: begin
            ill_exc = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = ALU_ADD;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_RTEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b00;
        unique case (funct)
          FN_ADD: begin
            aluop   = ALU_ADD;
            flagsel = 1'b1;
          end
          FN_SUB: begin
            aluop   = ALU_SUB;
            flagsel = 1'b1;
          end
          FN_OR: begin
            aluop = ALU_OR;
          end
          FN_SLT: begin
            aluop   = ALU_SUB;
            slt_sel = 1'b1;
          end
          default: begin
            aluop = ALU_ADD;
          end
        endcase
        ovf_d   = flag & flagsel;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = ~ovf_q;
        ovf_exc  = ovf_q;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        alusrcb = 2'b00;
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;
        pc_en   = zero;
        state_d = S_FETCH;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_ADDI) begin
          aluop   = ALU_ADD;
          flagsel = 1'b1;
        end else begin
          aluop   = ALU_OR;
          immzext = 1'b1;
        end
        // ALU inputs move after this cycle, so the flag is latched now
        ovf_d   = flag & flagsel;
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = ~ovf_q;
        ovf_exc  = ovf_q;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign state = state_q;

endmodule
